// File: rtl/multicycle_control_fsm_pkg.sv
// Shared definitions for the multi-cycle MIPS control sequencer:
// opcodes, state encodings, datapath select codes and the control vector.
package multicycle_control_fsm_pkg;

  // IR[31:26] opcodes
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;

  // Sequencer states; encodings are visible on the debug state port
  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_I_EXEC    = 4'd10,
    S_I_WB      = 4'd11,
    S_TRAP      = 4'd12
  } state_t;

  // ALUOp codes consumed by ALU_Control
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_AND   = 2'b11;

  // ALU operand B select
  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  // PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Per-cycle datapath control vector
  typedef struct packed {
    logic       pc_en;
    logic       ir_write;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal_op;
  } ctrl_t;

  // First execute-phase state for an opcode leaving DECODE
  function automatic state_t dispatch(input logic [5:0] op);
    state_t s;
    case (op)
      OP_LW, OP_SW:     s = S_MEM_ADDR;
      OP_RTYPE:         s = S_R_EXEC;
      OP_BEQ:           s = S_BRANCH;
      OP_J:             s = S_JUMP;
      OP_ADDI, OP_ANDI: s = S_I_EXEC;
      default:          s = S_TRAP;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/multicycle_control_fsm_decode.sv
// Moore output decode for the control sequencer: maps the current state
// (qualified by opcode, zero and mem_ready) to the datapath control vector.
module mips_ctrl_decode
  import multicycle_control_fsm_pkg::*;
(
  input  state_t     state,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output ctrl_t      ctrl
);

  logic [1:0] imm_alu_op;

  // Immediate ops share one datapath path; only the ALU function differs
  always_comb begin
    imm_alu_op = (opcode == OP_ANDI) ? ALUOP_AND : ALUOP_ADD;
  end

  // Per-state control outputs; anything not set for a state stays 0
  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_en     = mem_ready;
      end
      S_DECODE: begin
        ctrl.alu_src_b = SRCB_IMM_SH2;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEM_READ: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
      end
      S_MEM_WRITE: begin
        ctrl.mem_write = 1'b1;
        ctrl.i_or_d    = 1'b1;
      end
      S_R_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_R_WB: begin
        ctrl.reg_dst   = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_op    = ALUOP_SUB;
        ctrl.pc_source = PCSRC_ALUOUT;
        ctrl.pc_en     = zero;
      end
      S_JUMP: begin
        ctrl.pc_source = PCSRC_JUMP;
        ctrl.pc_en     = 1'b1;
      end
      S_I_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = imm_alu_op;
      end
      S_I_WB: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = imm_alu_op;
        ctrl.reg_write = 1'b1;
      end
      S_TRAP: begin
        ctrl.illegal_op = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Main control sequencer for the multi-cycle MIPS datapath. Holds the state
// register, next-state logic and retired-instruction counter, and gates the
// side-effecting enables with reset.
module multicycle_control_fsm
  import multicycle_control_fsm_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             ir_write,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             mem_to_reg,
  output logic             reg_dst,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_source,
  output logic             illegal_op,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] retired
);

  state_t     cur;
  state_t     nxt;
  ctrl_t      ctrl;
  logic       retire;

  mips_ctrl_decode u_decode (
    .state     (cur),
    .opcode    (opcode),
    .zero      (zero),
    .mem_ready (mem_ready),
    .ctrl      (ctrl)
  );

  // Next-state selection; memory states hold until mem_ready
  always_comb begin
    nxt = cur;
    case (cur)
      S_FETCH:     if (mem_ready) nxt = S_DECODE;
      S_DECODE:    nxt = dispatch(opcode);
      S_MEM_ADDR:  nxt = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ:  if (mem_ready) nxt = S_MEM_WB;
      S_MEM_WB:    nxt = S_FETCH;
      S_MEM_WRITE: if (mem_ready) nxt = S_FETCH;
      S_R_EXEC:    nxt = S_R_WB;
      S_R_WB:      nxt = S_FETCH;
      S_BRANCH:    nxt = S_FETCH;
      S_JUMP:      nxt = S_FETCH;
      S_I_EXEC:    nxt = S_I_WB;
      S_I_WB:      nxt = S_FETCH;
      S_TRAP:      nxt = S_TRAP;
      default:     nxt = S_FETCH;
    endcase
  end

  // An instruction retires on any transition back into FETCH
  always_comb begin
    retire = (nxt == S_FETCH) && (cur != S_FETCH);
  end

  // State register and wrapping retired-instruction counter
  always_ff @(posedge clk) begin
    if (reset) begin
      cur     <= S_FETCH;
      retired <= '0;
    end else begin
      cur <= nxt;
      if (retire) retired <= retired + CNT_W'(1);
    end
  end

  // Enables with side effects are suppressed while reset is held, even mid-access
  always_comb begin
    pc_en      = ctrl.pc_en     & ~reset;
    ir_write   = ctrl.ir_write  & ~reset;
    mem_read   = ctrl.mem_read  & ~reset;
    mem_write  = ctrl.mem_write & ~reset;
    reg_write  = ctrl.reg_write & ~reset;
    i_or_d     = ctrl.i_or_d;
    mem_to_reg = ctrl.mem_to_reg;
    reg_dst    = ctrl.reg_dst;
    alu_src_a  = ctrl.alu_src_a;
    alu_src_b  = ctrl.alu_src_b;
    alu_op     = ctrl.alu_op;
    pc_source  = ctrl.pc_source;
    illegal_op = ctrl.illegal_op;
    state      = cur;
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboard bench for multicycle_control_fsm. The driver walks each
// instruction through its state path, pushing the expected control vector
// for every cycle; a negedge monitor pops and compares. A second instance
// with a 2-bit counter checks retired wrap.
module tb_multicycle_control_fsm;

  typedef struct packed {
    logic [3:0]  st;
    logic        pc_en;
    logic        ir_write;
    logic        i_or_d;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
    logic        reg_dst;
    logic        reg_write;
    logic        alu_src_a;
    logic [1:0]  src_b;
    logic [1:0]  alu_op;
    logic [1:0]  pc_src;
    logic        illegal;
    logic [15:0] retired;
  } exp_t;

  typedef int path_t[$];

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;

  logic        pc_en, ir_write, i_or_d, mem_read, mem_write, mem_to_reg;
  logic        reg_dst, reg_write, alu_src_a, illegal_op;
  logic [1:0]  alu_src_b, alu_op, pc_source;
  logic [3:0]  state;
  logic [15:0] retired;

  logic        d2_pc_en, d2_ir_write, d2_i_or_d, d2_mem_read, d2_mem_write, d2_mem_to_reg;
  logic        d2_reg_dst, d2_reg_write, d2_alu_src_a, d2_illegal_op;
  logic [1:0]  d2_alu_src_b, d2_alu_op, d2_pc_source;
  logic [3:0]  d2_state;
  logic [1:0]  d2_retired;

  exp_t        exp_q[$];
  int unsigned errors = 0;
  int unsigned checks = 0;
  logic [15:0] model_ret;

  always #5 clk = ~clk;

  multicycle_control_fsm #(.CNT_W(16)) u_dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_en(pc_en), .ir_write(ir_write), .i_or_d(i_or_d), .mem_read(mem_read),
    .mem_write(mem_write), .mem_to_reg(mem_to_reg), .reg_dst(reg_dst),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .pc_source(pc_source), .illegal_op(illegal_op),
    .state(state), .retired(retired)
  );

  multicycle_control_fsm #(.CNT_W(2)) u_dut2 (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_en(d2_pc_en), .ir_write(d2_ir_write), .i_or_d(d2_i_or_d), .mem_read(d2_mem_read),
    .mem_write(d2_mem_write), .mem_to_reg(d2_mem_to_reg), .reg_dst(d2_reg_dst),
    .reg_write(d2_reg_write), .alu_src_a(d2_alu_src_a), .alu_src_b(d2_alu_src_b),
    .alu_op(d2_alu_op), .pc_source(d2_pc_source), .illegal_op(d2_illegal_op),
    .state(d2_state), .retired(d2_retired)
  );

  // Sequence of states an instruction visits, FETCH inclusive
  function automatic path_t path_of(input logic [5:0] opc);
    path_t p;
    case (opc)
      6'b000000:            p = '{0, 1, 6, 7};
      6'b100011:            p = '{0, 1, 2, 3, 4};
      6'b101011:            p = '{0, 1, 2, 5};
      6'b000100:            p = '{0, 1, 8};
      6'b000010:            p = '{0, 1, 9};
      6'b001000, 6'b001100: p = '{0, 1, 10, 11};
      default:              p = '{0, 1, 12};
    endcase
    return p;
  endfunction

  // Expected outputs for one cycle spent in state s
  function automatic exp_t expect_out(input int s, input logic [5:0] opc, input logic z,
                                      input logic mr, input logic rst, input logic [15:0] ret);
    exp_t e;
    e = '0;
    e.st = 4'(s);
    e.retired = ret;
    case (s)
      0:  begin e.mem_read = 1; e.src_b = 2'b01; e.ir_write = mr; e.pc_en = mr; end
      1:  e.src_b = 2'b11;
      2:  begin e.alu_src_a = 1; e.src_b = 2'b10; end
      3:  begin e.mem_read = 1; e.i_or_d = 1; end
      4:  begin e.mem_to_reg = 1; e.reg_write = 1; end
      5:  begin e.mem_write = 1; e.i_or_d = 1; end
      6:  begin e.alu_src_a = 1; e.alu_op = 2'b10; end
      7:  begin e.reg_dst = 1; e.reg_write = 1; end
      8:  begin e.alu_src_a = 1; e.alu_op = 2'b01; e.pc_src = 2'b01; e.pc_en = z; end
      9:  begin e.pc_src = 2'b10; e.pc_en = 1; end
      10: begin e.alu_src_a = 1; e.src_b = 2'b10; e.alu_op = (opc == 6'b001100) ? 2'b11 : 2'b00; end
      11: begin e.alu_src_a = 1; e.src_b = 2'b10; e.alu_op = (opc == 6'b001100) ? 2'b11 : 2'b00;
                e.reg_write = 1; end
      12: e.illegal = 1;
      default: ;
    endcase
    if (rst) begin
      e.pc_en = 0; e.ir_write = 0; e.mem_read = 0; e.mem_write = 0; e.reg_write = 0;
    end
    return e;
  endfunction

  // Drive one cycle and record what the DUT should show during it
  task automatic drive_cycle(input int s, input logic mr, input logic rst);
    mem_ready = mr;
    reset = rst;
    exp_q.push_back(expect_out(s, opcode, zero, mr, rst, model_ret));
    @(posedge clk);
    #1;
  endtask

  // One instruction: fw wait cycles in FETCH, mw in MEM_READ/MEM_WRITE
  task automatic run_instr(input logic [5:0] opc, input logic z, input int fw, input int mw);
    path_t p;
    p = path_of(opc);
    opcode = opc;
    zero = z;
    foreach (p[i]) begin
      if (p[i] == 0 || p[i] == 3 || p[i] == 5) begin
        repeat ((p[i] == 0) ? fw : mw) drive_cycle(p[i], 1'b0, 1'b0);
        drive_cycle(p[i], 1'b1, 1'b0);
      end else begin
        drive_cycle(p[i], 1'($urandom_range(0, 1)), 1'b0);
      end
    end
    if (p[p.size()-1] != 12) model_ret = model_ret + 16'd1;
  endtask

  // Monitor: compare both instances against the expected vector each cycle
  always @(negedge clk) begin
    exp_t e, a, e2, a2;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      a = {state, pc_en, ir_write, i_or_d, mem_read, mem_write, mem_to_reg, reg_dst,
           reg_write, alu_src_a, alu_src_b, alu_op, pc_source, illegal_op, retired};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL ctrl_vec t=%0t got=%h want=%h", $time, a, e);
      end
      e2 = e;
      e2.retired = {14'd0, e.retired[1:0]};
      a2 = {d2_state, d2_pc_en, d2_ir_write, d2_i_or_d, d2_mem_read, d2_mem_write,
            d2_mem_to_reg, d2_reg_dst, d2_reg_write, d2_alu_src_a, d2_alu_src_b,
            d2_alu_op, d2_pc_source, d2_illegal_op, 14'd0, d2_retired};
      checks++;
      if (a2 !== e2) begin
        errors++;
        $display("FAIL ctrl_vec_cnt2 t=%0t got=%h want=%h", $time, a2, e2);
      end
    end
  end

  initial begin
    logic [5:0] legal [7];
    legal = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000, 6'b001100};
    reset = 1'b1;
    opcode = 6'b000000;
    zero = 1'b0;
    mem_ready = 1'b1;
    model_ret = 16'd0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Directed cases
    run_instr(6'b000000, 1'b0, 0, 0);  // R-type
    run_instr(6'b100011, 1'b0, 2, 1);  // lw with wait states
    run_instr(6'b000100, 1'b1, 0, 0);  // beq taken
    run_instr(6'b000100, 1'b0, 0, 0);  // beq not taken
    run_instr(6'b001100, 1'b0, 0, 0);  // andi
    run_instr(6'b001000, 1'b0, 0, 0);  // addi
    run_instr(6'b000010, 1'b0, 0, 0);  // j
    run_instr(6'b101011, 1'b0, 1, 2);  // sw with wait states
    repeat (5) run_instr(6'b000000, 1'b0, 0, 0);

    // Randomised legal instruction stream
    repeat (150)
      run_instr(legal[$urandom_range(0, 6)], 1'($urandom_range(0, 1)),
                int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));

    // sw stalled in MEM_WRITE, then reset during the access
    opcode = 6'b101011;
    zero = 1'b0;
    drive_cycle(0, 1'b1, 1'b0);
    drive_cycle(1, 1'b1, 1'b0);
    drive_cycle(2, 1'b0, 1'b0);
    drive_cycle(5, 1'b0, 1'b0);
    drive_cycle(5, 1'b0, 1'b1);
    model_ret = 16'd0;
    run_instr(6'b000000, 1'b0, 0, 0);

    // Illegal opcode traps until reset
    run_instr(6'b111111, 1'b0, 0, 0);
    repeat (9) drive_cycle(12, 1'($urandom_range(0, 1)), 1'b0);
    drive_cycle(12, 1'b1, 1'b1);
    model_ret = 16'd0;
    run_instr(6'b000000, 1'b0, 1, 0);

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got=%0d want=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
